// File: rtl/alu32_op_seq_if.sv
// Request, gate-unit and response signals of the ALU32 operation sequencer.
// The slave modport is the sequencer; the master modport is its environment
// (request source, gate units and writeback consumer).
interface alu32_op_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ReqValid;
  logic             ReqReady;
  logic [2:0]       Op;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic             AndEn;
  logic             OrEn;
  logic             XorEn;
  logic [WIDTH-1:0] GateA;
  logic [WIDTH-1:0] GateB;
  logic [WIDTH-1:0] GateOut;
  logic             RespValid;
  logic             RespReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Err;

  modport master (
    output ReqValid, Op, InA, InB, GateOut, RespReady,
    input  ReqReady, AndEn, OrEn, XorEn, GateA, GateB, RespValid, Result, Zero, Err
  );

  modport slave (
    input  ReqValid, Op, InA, InB, GateOut, RespReady,
    output ReqReady, AndEn, OrEn, XorEn, GateA, GateB, RespValid, Result, Zero, Err
  );
endinterface

// File: rtl/alu32_op_seq.sv
// ALU32 operation sequencer: drives one gate-unit enable for logic ops,
// shifts internally one bit per cycle, and returns a registered result.
module alu32_op_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned GATE_WAIT = 1
) (
  input logic           Clk,
  input logic           Rst,
  alu32_op_seq_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGate  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpNor = 3'b011;
  localparam logic [2:0] OpSll = 3'b100;
  localparam logic [2:0] OpSrl = 3'b101;
  localparam logic [2:0] OpSra = 3'b110;
  localparam logic [2:0] OpIll = 3'b111;

  // Wait counter counts down to zero; zero marks the capture cycle.
  localparam logic [3:0] WaitInit = 4'(GATE_WAIT - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] gate_a_q, gate_a_d;
  logic [WIDTH-1:0] gate_b_q, gate_b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       wait_q, wait_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] gate_res;

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    gate_res = (op_q == OpNor) ? ~bus.GateOut : bus.GateOut;

    case (state_q)
      StIdle: begin
        if (bus.ReqValid) begin
          op_d     = bus.Op;
          gate_a_d = bus.InA;
          gate_b_d = bus.InB;
          work_d   = bus.InA;
          cnt_d    = bus.InB[4:0];
          wait_d   = WaitInit;
          if (!bus.Op[2]) begin
            state_d = StGate;
          end else if (bus.Op == OpIll) begin
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = StResp;
          end else begin
            state_d = StShift;
          end
        end
      end
      StGate: begin
        if (wait_q == 4'd0) begin
          result_d = gate_res;
          zero_d   = (gate_res == '0);
          err_d    = 1'b0;
          state_d  = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StShift: begin
        if (cnt_q != 5'd0) begin
          case (op_q)
            OpSll:   work_d = work_q << 1;
            OpSrl:   work_d = work_q >> 1;
            OpSra:   work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_d = work_q;
          endcase
          cnt_d = cnt_q - 5'd1;
        end else begin
          result_d = work_q;
          zero_d   = (work_q == '0);
          err_d    = 1'b0;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (bus.RespReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StIdle;
      op_q     <= OpAnd;
      gate_a_q <= '0;
      gate_b_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Output decode: enables only in GATE, so at most one is ever high.
  always_comb begin
    bus.ReqReady  = (state_q == StIdle) && !Rst;
    bus.AndEn     = (state_q == StGate) && (op_q == OpAnd);
    bus.OrEn      = (state_q == StGate) && ((op_q == OpOr) || (op_q == OpNor));
    bus.XorEn     = (state_q == StGate) && (op_q == OpXor);
    bus.GateA     = gate_a_q;
    bus.GateB     = gate_b_q;
    bus.RespValid = (state_q == StResp);
    bus.Result    = result_q;
    bus.Zero      = zero_q;
    bus.Err       = err_q;
  end

endmodule

// File: tb/tb_alu32_op_seq.sv
// Scoreboard bench for alu32_op_seq: the driver pushes expected responses
// from a plain-arithmetic model, the monitor pops and compares them.
module tb_alu32_op_seq;

  localparam int unsigned GW = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  alu32_op_seq_if #(.WIDTH(32)) bus ();

  alu32_op_seq #(
    .WIDTH    (32),
    .GATE_WAIT(GW)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // Gate units: disabled units drive zero onto the shared bus.
  assign bus.GateOut = (bus.AndEn ? (bus.GateA & bus.GateB) : 32'h0)
                     | (bus.OrEn  ? (bus.GateA | bus.GateB) : 32'h0)
                     | (bus.XorEn ? (bus.GateA ^ bus.GateB) : 32'h0);

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          lat;
    int          acc;
    int          n_and;
    int          n_or;
    int          n_xor;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr_mode = 0;
  int   last_hs = 0;
  bit   have_hs = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Consumer: always ready, random, or stalled.
  always @(posedge Clk) begin
    #1;
    case (rr_mode)
      0:       bus.RespReady = 1'b1;
      1:       bus.RespReady = 1'($urandom_range(0, 1));
      default: bus.RespReady = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    int   k;
    k       = int'(b[4:0]);
    e.n_and = 0;
    e.n_or  = 0;
    e.n_xor = 0;
    e.err   = 1'b0;
    e.acc   = 0;
    e.lat   = k + 2;
    case (op)
      3'd0: begin e.res = a & b;    e.n_and = GW; e.lat = GW + 1; end
      3'd1: begin e.res = a | b;    e.n_or  = GW; e.lat = GW + 1; end
      3'd2: begin e.res = a ^ b;    e.n_xor = GW; e.lat = GW + 1; end
      3'd3: begin e.res = ~(a | b); e.n_or  = GW; e.lat = GW + 1; end
      3'd4: e.res = a << k;
      3'd5: e.res = a >> k;
      3'd6: e.res = 32'($signed(a) >>> k);
      default: begin e.res = 32'h0; e.err = 1'b1; e.lat = 1; end
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Present a request and hold it until accepted; push its expectation.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   done = 0;
    @(posedge Clk);
    #1;
    bus.ReqValid = 1'b1;
    bus.Op       = op;
    bus.InA      = a;
    bus.InB      = b;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge Clk);
      if (bus.ReqReady) begin
        e     = model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        if (have_hs) check("accept_after_handshake", 32'(cyc > last_hs), 32'd1);
        done = 1;
      end else begin
        @(posedge Clk);
        #1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
    bus.ReqValid = 1'b0;
    bus.Op       = 3'($urandom);
    bus.InA      = $urandom;
    bus.InB      = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: enable sanity every cycle, response compare against queue head.
  int n_and = 0, n_or = 0, n_xor = 0;
  bit seen = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      n_and = 0;
      n_or  = 0;
      n_xor = 0;
      seen  = 0;
    end else begin
      check("enable_onehot", 32'($countones({bus.AndEn, bus.OrEn, bus.XorEn}) <= 1), 32'd1);
      n_and += int'(bus.AndEn);
      n_or  += int'(bus.OrEn);
      n_xor += int'(bus.XorEn);
      if (bus.RespValid) begin
        check("enables_in_resp", 32'({bus.AndEn, bus.OrEn, bus.XorEn}), 32'd0);
        check("req_ready_in_resp", 32'(bus.ReqReady), 32'd0);
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          if (!seen) begin
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("and_en_cycles", 32'(n_and), 32'(e.n_and));
            check("or_en_cycles", 32'(n_or), 32'(e.n_or));
            check("xor_en_cycles", 32'(n_xor), 32'(e.n_xor));
            seen = 1;
          end
          check("result", bus.Result, e.res);
          check("zero", 32'(bus.Zero), 32'(e.zero));
          check("err", 32'(bus.Err), 32'(e.err));
          if (bus.RespReady) begin
            void'(sb.pop_front());
            seen    = 0;
            n_and   = 0;
            n_or    = 0;
            n_xor   = 0;
            last_hs = cyc;
            have_hs = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ReqValid = 1'b0;
    bus.Op       = 3'd0;
    bus.InA      = 32'h0;
    bus.InB      = 32'h0;
    Rst          = 1'b1;

    // Reset state
    @(negedge Clk);
    check("rst_req_ready", 32'(bus.ReqReady), 32'd0);
    check("rst_resp_valid", 32'(bus.RespValid), 32'd0);
    check("rst_result", bus.Result, 32'h0);
    check("rst_flags", 32'({bus.Zero, bus.Err}), 32'd0);
    check("rst_enables", 32'({bus.AndEn, bus.OrEn, bus.XorEn}), 32'd0);
    check("rst_gate_ab", bus.GateA | bus.GateB, 32'h0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("post_rst_req_ready", 32'(bus.ReqReady), 32'd1);

    // Directed operations
    issue(3'b001, 32'h0000_F0F0, 32'h0F0F_0000);
    issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(3'b110, 32'h8000_0010, 32'd4);
    issue(3'b100, 32'h1234_5678, 32'd0);
    issue(3'b100, 32'h1234_5678, 32'hFFFF_FFE1);
    issue(3'b101, 32'h8000_0001, 32'd31);
    issue(3'b111, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    drain();

    // Backpressure: stalled response while a second request waits
    rr_mode = 2;
    issue(3'b000, 32'hFF00_FF00, 32'hF0F0_F0F0);
    fork
      issue(3'b001, 32'h0000_0001, 32'h0000_0002);
      begin
        repeat (GW + 6) @(negedge Clk);
        rr_mode = 0;
      end
    join
    drain();

    // Reset in the middle of a long shift
    issue(3'b100, 32'h0000_0001, 32'd20);
    repeat (4) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_req_ready", 32'(bus.ReqReady), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    sb.delete();
    @(negedge Clk);
    check("midrst_enables", 32'({bus.AndEn, bus.OrEn, bus.XorEn}), 32'd0);
    check("midrst_resp_valid", 32'(bus.RespValid), 32'd0);
    check("midrst_result", bus.Result, 32'h0);
    check("midrst_req_ready", 32'(bus.ReqReady), 32'd1);
    issue(3'b010, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    drain();

    // Randomized traffic with random backpressure
    rr_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] b;
      b = $urandom;
      if (i % 3 == 0) b[4:0] = 5'($urandom_range(0, 3));
      issue(3'($urandom_range(0, 7)), $urandom, b);
    end
    drain();
    rr_mode = 0;
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_op_seq.md
Name: alu32_op_seq

Overview:
- Multi-cycle sequencer on the driving side of the ALU32 gate-unit Enable interface.
- Accepts one operation request at a time through a valid/ready handshake.
- Logic ops: raises exactly one gate-unit Enable and captures the shared gate output bus.
- Shifts: computed internally, one bit per cycle.
- Registered result and flags are returned through a second valid/ready handshake toward the datapath/register-file writeback.

Parameters:
- WIDTH, 32, operand/result width; shift amount taken from InB[4:0]. Only 32 is supported.
- GATE_WAIT, 1, number of cycles Enable is held high before GateOut is captured. Legal range 1..15.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  sequencer can accept a request (high only in IDLE)
- Op  in  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLL, 101 SRL, 110 SRA, 111 illegal
- InA  in  32  operand A
- InB  in  32  operand B; shifts use InB[4:0]
- AndEn  out  1  enable to 32-bit AND gate unit
- OrEn  out  1  enable to 32-bit OR gate unit (also used for NOR)
- XorEn  out  1  enable to 32-bit XOR gate unit
- GateA  out  32  latched operand A to gate units
- GateB  out  32  latched operand B to gate units
- GateOut  in  32  bitwise OR of all gate-unit outputs; disabled units drive 0
- RespValid  out  1  result available
- RespReady  in  1  consumer accepts result
- Result  out  32  registered result
- Zero  out  1  Result == 0, registered with Result
- Err  out  1  illegal Op flag, registered with Result

Behaviour:
- Reset: state IDLE; ReqReady 0 during the reset cycle, 1 from the first cycle after Rst deasserts. AndEn/OrEn/XorEn 0, GateA/GateB 0, RespValid 0, Result 0, Zero 0, Err 0, shift counter 0, wait counter 0.
- Reset mid-operation aborts unconditionally. Enables drop to 0 on the next edge and any pending response is discarded.
- States: IDLE, GATE, SHIFT, RESP.
- IDLE:
  - ReqReady=1. Accept on ReqValid && ReqReady: latch Op, InA into GateA, InB into GateB.
  - Op 000-011 -> GATE. Op 100-110 -> SHIFT, counter = InB[4:0]. Op 111 -> RESP with Result=0, Zero=1, Err=1.
- GATE:
  - Exactly one enable high for GATE_WAIT cycles: AndEn for 000, OrEn for 001/011, XorEn for 010.
  - On the last cycle, capture GateOut into Result (inverted for NOR) and go to RESP. Enables are 0 in RESP.
  - Never more than one enable high in any cycle.
- SHIFT:
  - Each cycle with counter != 0: working value shifts by 1 (SLL zero-fill left; SRL zero-fill right; SRA replicates bit 31); counter decrements.
  - On a cycle with counter == 0: load working value into Result and go to RESP.
  - SHIFT lasts k+1 cycles for amount k (k=0 gives 1 cycle, Result = InA).
- Latency, measured from the accept edge to the first cycle RespValid=1:
  - Logic ops: GATE_WAIT+1 cycles.
  - Shifts: k+2 cycles.
  - Illegal op: 1 cycle.
- RESP:
  - RespValid=1. Result/Zero/Err stable until RespValid && RespReady; then IDLE on the next edge.
  - RespValid may stay high indefinitely while RespReady=0.
  - ReqReady=0 in every state except IDLE. No request is accepted in the cycle the response completes, so the minimum request-to-request spacing is latency+1.
- Zero and Err update only when Result loads. Err=0 for all legal ops.
- ReqValid while busy is ignored (not latched). InA/InB/Op changes after accept have no effect.

Test Plan:
- OR: InA=0x0000_F0F0, InB=0x0F0F_0000, Op=001, GATE_WAIT=1 -> OrEn high exactly 1 cycle; RespValid at accept+2; Result=0x0F0F_F0F0, Zero=0, Err=0.
- NOR with zero result: InA=0xFFFF_FFFF, InB=0, Op=011, gate model returns OR -> Result=0x0000_0000, Zero=1; AndEn/XorEn never high.
- SRA: InA=0x8000_0010, InB=4, Op=110 -> Result=0xF800_0001; RespValid at accept+6. SLL with InB=0 -> Result=InA at accept+2. SLL with InB=0xFFFF_FFE1 -> shift by 1 only.
- Backpressure: complete AND, hold RespReady=0 for 5 cycles while pulsing ReqValid -> Result stable, ReqReady=0, second request not taken until one cycle after the handshake.
- Illegal Op=111 -> RespValid at accept+1, Result=0, Zero=1, Err=1, no enable asserted.
- Reset mid-SLL by 20 (assert Rst at accept+5) -> next cycle all enables 0, RespValid=0, Result=0, ReqReady=1 the cycle after Rst drops; a fresh XOR 0xAAAA_AAAA^0xFFFF_FFFF then gives 0x5555_5555.
